// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART transmitter definitions: shifter state encoding, the UART MMIO
// address, and the line level each shifter state drives.
package uart_tx_buffer_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Store target decoded by the memory controller; kept here so both agree.
  localparam logic [31:0] UART_MMIO_ADDR = 32'h1000_0000;

  function automatic logic line_level(input uart_state_e st, input logic data_bit);
    case (st)
      UART_START: return 1'b0;
      UART_DATA:  return data_bit;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered full/empty, an explicit occupancy count
// and a sticky overflow flag for writes dropped while full.
module uart_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  // Push is gated by the registered full flag even if a pop happens on the same edge.
  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  // NOTE: every signal assigned here gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty/count guard every read, so RAM can be inferred.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: CPU byte stores queue in uart_fifo and a
// baud-timed shifter drains them onto uart_tx with back-to-back frames.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter  int CLK_FREQ = 27_000_000,
  parameter  int BAUD     = 115_200,
  parameter  int DEPTH    = 16,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          cpu_resetn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic          tx_busy,
  output logic          uart_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic          baud_last;
  logic          pop;
  logic [7:0]    fifo_rd_data;

  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (cpu_resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (baud_last) begin
          state_d   = UART_DATA;
          bit_idx_d = 3'd0;
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      UART_STOP: begin
        // Reloading straight from STOP keeps consecutive frames gap-free.
        if (baud_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end
      end
    endcase

    if (state_q == UART_IDLE || baud_last) baud_d = '0;
    else                                   baud_d = baud_q + BW'(1);

    uart_tx_d = line_level(state_d, shift_d[0]);
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q   <= UART_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign tx_busy = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a frame-timing reference model is compared
// every cycle, a line decoder recovers bytes, and directed cases pin exact timings.
module tb_uart_tx_buffer;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 16;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * C;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          cpu_resetn;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          tx_busy;
  logic          uart_tx;

  always #5 clk = ~clk;

  uart_tx_buffer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .cpu_resetn (cpu_resetn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the age of the frame on the line.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_ready;
  int         m_size;

  initial forever begin
    @(posedge clk or negedge cpu_resetn);
    if (!cpu_resetn) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_ready = !m_active || (m_t == FRAME - 1);
      m_size  = m_q.size();
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) m_active = 1'b0;
      end
      if (m_ready && m_size > 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (wr_en) begin
        if (m_size < DEPTH) m_q.push_back(wr_data);
        else                m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / C;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  // Compare process and mid-bit line decoder.
  logic [7:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_t      = 0;
  logic [7:0] rx_byte   = 8'h00;

  initial forever begin
    @(negedge clk);
    check("uart_tx",    32'(uart_tx),    32'(exp_line()));
    check("tx_busy",    32'(tx_busy),    32'(m_active));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    check("overflow",   32'(overflow),   32'(m_ovf));
    if (!cpu_resetn) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % C == C / 2 && rx_t / C >= 1 && rx_t / C <= 8) rx_byte[rx_t/C-1] = uart_tx;
      if (rx_t == 9 * C + C / 2) begin
        check("rx_stop_bit", 32'(uart_tx), 32'd1);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    #2 cpu_resetn = 1'b0;
    repeat (3) @(negedge clk);
    cpu_resetn = 1'b1;
    @(negedge clk);
  endtask

  logic [9:0] t2_bits;
  logic [7:0] sent[$];
  int         waited;
  int         lows;

  initial begin
    cpu_resetn = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("t1_uart_tx",    32'(uart_tx),    32'd1);
    check("t1_fifo_empty", 32'(fifo_empty), 32'd1);
    check("t1_fifo_full",  32'(fifo_full),  32'd0);
    check("t1_fifo_count", 32'(fifo_count), 32'd0);
    check("t1_overflow",   32'(overflow),   32'd0);
    check("t1_tx_busy",    32'(tx_busy),    32'd0);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single 0x55 frame, start bit one edge after the push
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    check("t2_count_after_push", 32'(fifo_count), 32'd1);
    check("t2_line_still_high",  32'(uart_tx),    32'd1);
    @(negedge clk);
    check("t2_start_fall", 32'(uart_tx), 32'd0);
    t2_bits = 10'b10_1010_1010;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2_bit%0d", i), 32'(uart_tx), 32'(t2_bits[i]));
      if (i < 9) repeat (10) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("t2_busy_at_100", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("t2_busy_drop", 32'(tx_busy), 32'd0);
    check("t2_line_idle", 32'(uart_tx), 32'd1);
    check("t2_rx_count",  32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t2_rx_byte", 32'(rx_q[0]), 32'h55);
    rx_q.delete();

    // 3: 17 writes fill the FIFO, the 18th overflows, frames are contiguous
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
    end
    check("t3_count_full", 32'(fifo_count), 32'd16);
    check("t3_full",       32'(fifo_full),  32'd1);
    check("t3_no_ovf_yet", 32'(overflow),   32'd0);
    wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("t3_overflow",       32'(overflow),   32'd1);
    check("t3_count_unchanged", 32'(fifo_count), 32'd16);
    waited = 0;
    while (tx_busy && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("t3_busy_span", 32'(waited), 32'd1684);
    check("t3_rx_count", 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++)
      check($sformatf("t3_rx_byte%0d", i), 32'(rx_q[i]), 32'(i));
    rx_q.delete();
    reset_pulse();

    // 4: write while full on the STOP-end pop edge is dropped
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (84) @(negedge clk);
    check("t4_count_before", 32'(fifo_count), 32'd16);
    check("t4_full_before",  32'(fifo_full),  32'd1);
    check("t4_ovf_before",   32'(overflow),   32'd0);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count_after", 32'(fifo_count), 32'd15);
    check("t4_ovf_after",   32'(overflow),   32'd1);
    check("t4_full_after",  32'(fifo_full),  32'd0);
    reset_pulse();
    rx_q.delete();

    // 5: async reset in the middle of DATA bit 3
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = (i == 0) ? 8'hA5 : 8'(8'h10 * i + i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (42) @(negedge clk);
    check("t5_busy_before",  32'(tx_busy),    32'd1);
    check("t5_bit3_level",   32'(uart_tx),    32'd0);
    check("t5_count_before", 32'(fifo_count), 32'd3);
    #2 cpu_resetn = 1'b0;
    #1;
    check("t5_async_line",  32'(uart_tx),    32'd1);
    check("t5_async_count", 32'(fifo_count), 32'd0);
    check("t5_async_busy",  32'(tx_busy),    32'd0);
    repeat (3) @(negedge clk);
    cpu_resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_no_residual_low", 32'(lows), 32'd0);
    check("t5_rx_none",         32'(rx_q.size()), 32'd0);

    // 6: 40 random bytes paced against the model occupancy, pointers wrap
    sent.delete();
    while (sent.size() < 40) begin
      if (m_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        sent.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    waited = 0;
    while (rx_q.size() < 40 && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    check("t6_rx_timeout", 32'(rx_q.size() >= 40), 32'd1);
    for (int i = 0; i < 40 && i < rx_q.size(); i++)
      check($sformatf("t6_rx_byte%0d", i), 32'(rx_q[i]), 32'(sent[i]));
    check("t6_no_overflow", 32'(overflow), 32'd0);

    // Random free-running traffic including overflow
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    waited = 0;
    while ((m_active || m_q.size() != 0) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check("rand_drain_timeout", 32'(waited < 4000), 32'd1);
    repeat (5) @(negedge clk);
    check("rand_final_idle", 32'(tx_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
